// File: rtl/apple_spawner.sv
// Apple placement for the 16x16 snake board: LFSR picks, linear-scan fallback.
// Holds the apple until eaten; reports a sticky full board when no cell is free.
module apple_spawner #(
    parameter int unsigned RANDOM_TRIES = 16,
    parameter logic [7:0]  LFSR_SEED    = 8'h01
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               appleEaten,
    input  logic [15:0][15:0]  snakePixels,
    output logic [15:0][15:0]  RedPixels,
    output logic [3:0]         appleX,
    output logic [3:0]         appleY,
    output logic               appleValid,
    output logic               boardFull
);

    typedef enum logic [1:0] {
        SEARCH_RAND,
        SEARCH_SCAN,
        PLACED,
        FULL
    } state_t;

    localparam logic [7:0] LAST_TRY = 8'(RANDOM_TRIES - 1);

    state_t            state, state_d;
    logic [7:0]        lfsr, lfsr_d;
    logic [7:0]        tries, tries_d;
    logic [7:0]        scanIdx, scanIdx_d;
    logic [15:0][15:0] red_d;
    logic [3:0]        x_d, y_d;
    logic              valid_d, full_d;
    logic [7:0]        cand;
    logic              candBusy;

    // The cell under test comes from the LFSR or the scan counter.
    assign cand     = (state == SEARCH_SCAN) ? scanIdx : lfsr;
    assign candBusy = snakePixels[cand[7:4]][cand[3:0]];

    always_comb begin
        lfsr_d    = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        state_d   = state;
        tries_d   = tries;
        scanIdx_d = scanIdx;
        red_d     = RedPixels;
        x_d       = appleX;
        y_d       = appleY;
        valid_d   = appleValid;
        full_d    = boardFull;
        if (enable) begin
            unique case (state)
                SEARCH_RAND, SEARCH_SCAN: begin
                    if (!candBusy) begin
                        red_d                       = '0;
                        red_d[cand[7:4]][cand[3:0]] = 1'b1;
                        x_d                         = cand[7:4];
                        y_d                         = cand[3:0];
                        valid_d                     = 1'b1;
                        state_d                     = PLACED;
                    end else if (state == SEARCH_RAND) begin
                        if (tries == LAST_TRY) begin
                            state_d   = SEARCH_SCAN;
                            scanIdx_d = 8'd0;
                        end else begin
                            tries_d = tries + 8'd1;
                        end
                    end else if (scanIdx == 8'hff) begin
                        red_d   = '0;
                        valid_d = 1'b0;
                        full_d  = 1'b1;
                        state_d = FULL;
                    end else begin
                        scanIdx_d = scanIdx + 8'd1;
                    end
                end
                PLACED: begin
                    if (appleEaten) begin
                        red_d   = '0;
                        valid_d = 1'b0;
                        tries_d = 8'd0;
                        state_d = SEARCH_RAND;
                    end
                end
                FULL: begin
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= SEARCH_RAND;
            lfsr       <= LFSR_SEED;
            tries      <= 8'd0;
            scanIdx    <= 8'd0;
            RedPixels  <= '0;
            appleX     <= 4'd0;
            appleY     <= 4'd0;
            appleValid <= 1'b0;
            boardFull  <= 1'b0;
        end else begin
            state      <= state_d;
            lfsr       <= lfsr_d;
            tries      <= tries_d;
            scanIdx    <= scanIdx_d;
            RedPixels  <= red_d;
            appleX     <= x_d;
            appleY     <= y_d;
            appleValid <= valid_d;
            boardFull  <= full_d;
        end
    end

endmodule

// File: tb/tb_apple_spawner.sv
// Bench for apple_spawner: directed and random boards against a
// placement predictor built from the candidate order (random tries, then scan).
module tb_apple_spawner;

    localparam int RT = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b0;
    logic              appleEaten = 1'b0;
    logic [15:0][15:0] snakePixels = '0;
    logic [15:0][15:0] RedPixels;
    logic [3:0]        appleX, appleY;
    logic              appleValid, boardFull;

    int errors = 0;
    int checks = 0;
    int edges  = 0;
    logic [3:0] m_x = 4'd0;
    logic [3:0] m_y = 4'd0;
    logic       m_valid = 1'b0;
    logic       m_full = 1'b0;

    apple_spawner #(
        .RANDOM_TRIES(RT),
        .LFSR_SEED(8'h01)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .appleEaten(appleEaten),
        .snakePixels(snakePixels),
        .RedPixels(RedPixels),
        .appleX(appleX),
        .appleY(appleY),
        .appleValid(appleValid),
        .boardFull(boardFull)
    );

    always #5 clk = ~clk;

    // LFSR value n steps after the seed
    function automatic logic [7:0] lfsr_at(int n);
        logic [7:0] l;
        l = 8'h01;
        for (int i = 0; i < n; i++)
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        return l;
    endfunction

    function automatic logic [255:0] onehot(logic [3:0] x, logic [3:0] y);
        logic [15:0][15:0] r;
        r = '0;
        r[x][y] = 1'b1;
        return r;
    endfunction

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(string tag);
        chk({tag, ".red"}, RedPixels, m_valid ? onehot(m_x, m_y) : 256'd0);
        chk({tag, ".x"}, 256'(appleX), 256'(m_x));
        chk({tag, ".y"}, 256'(appleY), 256'(m_y));
        chk({tag, ".valid"}, 256'(appleValid), 256'(m_valid));
        chk({tag, ".full"}, 256'(boardFull), 256'(m_full));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        m_x = 4'd0; m_y = 4'd0; m_valid = 1'b0; m_full = 1'b0;
        chk_all("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        edges = 0;
    endtask

    // Candidate order: RT LFSR values from the current edge, then cells 0..255
    task automatic predict(output int lat, output logic full,
                           output logic [3:0] px, output logic [3:0] py);
        logic [7:0] c;
        full = 1'b1; lat = RT + 256; px = 4'd0; py = 4'd0;
        for (int i = 0; i < RT; i++) begin
            c = lfsr_at(edges + i);
            if (!snakePixels[c[7:4]][c[3:0]]) begin
                lat = i + 1; full = 1'b0; px = c[7:4]; py = c[3:0];
                return;
            end
        end
        for (int k = 0; k < 256; k++) begin
            c = 8'(k);
            if (!snakePixels[c[7:4]][c[3:0]]) begin
                lat = RT + 1 + k; full = 1'b0; px = c[7:4]; py = c[3:0];
                return;
            end
        end
    endtask

    task automatic run_search(string tag, int want_lat);
        int lat;
        logic f;
        logic [3:0] px, py;
        predict(lat, f, px, py);
        if (want_lat > 0)
            chk({tag, ".pred_lat"}, 256'(lat), 256'(want_lat));
        for (int i = 1; i < lat; i++) tick();
        if (lat > 1) begin
            chk({tag, ".early_valid"}, 256'(appleValid), 256'd0);
            chk({tag, ".early_full"}, 256'(boardFull), 256'd0);
        end
        tick();
        if (f) begin
            m_full = 1'b1; m_valid = 1'b0;
        end else begin
            m_x = px; m_y = py; m_valid = 1'b1;
        end
        chk_all(tag);
    endtask

    task automatic eat();
        appleEaten = 1'b1;
        tick();
        appleEaten = 1'b0;
        if (!m_full) m_valid = 1'b0;
        chk_all("eaten");
    endtask

    task automatic rand_board(int dens);
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                snakePixels[x][y] = ($urandom_range(0, 99) < dens);
    endtask

    initial begin
        enable = 1'b1;
        do_reset();
        run_search("empty", 1);
        chk("empty.x01", 256'({appleX, appleY}), 256'(8'h01));

        enable = 1'b0;
        appleEaten = 1'b1;
        tick();
        appleEaten = 1'b0;
        chk_all("eat_disabled");
        enable = 1'b1;
        eat();
        chk("eat.red_zero", RedPixels, 256'd0);

        for (int r = 0; r < 8; r++) begin
            rand_board((r % 3 == 2) ? 99 : int'($urandom_range(20, 95)));
            run_search("rand", 0);
            if (!m_full) eat();
        end

        snakePixels = '0;
        snakePixels[0][1] = 1'b1;
        do_reset();
        run_search("skip01", 2);
        chk("skip01.xy", 256'({appleX, appleY}), 256'(8'h02));

        snakePixels = '1;
        snakePixels[9][9] = 1'b0;
        do_reset();
        run_search("last99", 170);

        snakePixels = '1;
        do_reset();
        run_search("full", 272);
        eat();
        tick();
        chk_all("full_hold");
        do_reset();

        snakePixels = '0;
        enable = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk_all("en0_search");
        enable = 1'b1;
        run_search("late_enable", 0);
        eat();

        snakePixels = '1;
        for (int i = 0; i < RT + 10; i++) tick();
        chk_all("in_scan");
        reset = 1'b0;
        #1;
        m_x = 4'd0; m_y = 4'd0; m_valid = 1'b0; m_full = 1'b0;
        chk_all("async_rst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        edges = 0;
        snakePixels = '0;
        run_search("after_rst", 1);
        chk("after_rst.xy", 256'({appleX, appleY}), 256'(8'h01));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apple_spawner.md
# apple_spawner

Places the apple on the 16x16 snake board and drives the `RedPixels` occupancy map consumed by the apple-eaten detector. It picks a pseudo-random free cell, using an 8-bit LFSR with a bounded deterministic linear-scan fallback. It holds the apple until it receives an eaten pulse, then clears the apple and searches for a new cell. If no free cell exists, it reports a full board. It sits between the snake body tracker (`snakePixels` source) and the apple-eaten detector (`win` → `appleEaten`).

## Interface
Parameters:
- `RANDOM_TRIES`, 16: random candidates tested before falling back to linear scan (1..255).
- `LFSR_SEED`, 8'h01: LFSR reset value; must be non-zero.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  game-step qualifier; FSM and counters advance only when 1.
- `appleEaten`  in  1  one-cycle pulse from the eaten detector (its `win`).
- `snakePixels`  in  [15:0][15:0]  body occupancy, indexed `[x][y]`; 1 = occupied.
- `RedPixels`  out  [15:0][15:0]  apple map, indexed `[x][y]`; all-zero or one-hot.
- `appleX`, `appleY`  out  4 each  current apple coordinates.
- `appleValid`  out  1  apple is on the board.
- `boardFull`  out  1  no free cell found; sticky until reset.

## Operation
- LFSR, 8 bits, Fibonacci: `next = {l[6:0], l[7]^l[5]^l[4]^l[3]}`.
  - Maximal period 255; never 0.
  - Advances on every clk edge regardless of `enable` or state.
- Candidate cell is x = `lfsr[7:4]`, y = `lfsr[3:0]`, taken from the pre-edge LFSR value.
- States: SEARCH_RAND, SEARCH_SCAN, PLACED, FULL. Reset state is SEARCH_RAND with `tries` = 0.
- SEARCH_RAND (with `enable`=1 each edge):
  - Candidate free (`snakePixels[x][y]`=0): latch `appleX`/`appleY`, set `RedPixels[x][y]`=1 and `appleValid`=1, go to PLACED.
  - Candidate occupied: `tries`++. When `tries` reaches `RANDOM_TRIES`−1 and still occupied, go to SEARCH_SCAN with `scanIdx` = 0.
- SEARCH_SCAN (with `enable`=1 each edge):
  - Test cell x = `scanIdx[7:4]`, y = `scanIdx[3:0]`.
  - Free: place the apple as above, go to PLACED.
  - Occupied and `scanIdx` = 255: set `boardFull`=1, go to FULL.
  - Otherwise `scanIdx`++. The 8-bit counter never wraps.
- PLACED: `appleEaten`=1 with `enable`=1 clears `RedPixels` to 0 and `appleValid` to 0, resets `tries` to 0, and goes to SEARCH_RAND.
- FULL: terminal. `RedPixels` = 0 and `appleValid` = 0; all inputs are ignored until reset.
- `appleEaten` is ignored in SEARCH_RAND, SEARCH_SCAN and FULL.
- `snakePixels` is sampled only for the cell under test in the current cycle. The block does not re-check after placement.

## Timing
- Reset values (asynchronous, immediate on `reset`=0):
  - LFSR = `LFSR_SEED`.
  - `RedPixels` = 0, `appleX` = 0, `appleY` = 0, `appleValid` = 0, `boardFull` = 0.
  - `tries` = 0, `scanIdx` = 0.
- A reset asserted mid-search or mid-placement aborts it with no partial update.
- `enable`=0: state, `tries`, `scanIdx` and outputs hold; only the LFSR advances.
- Placement latency, counted in enabled edges after entering SEARCH_RAND:
  - Best case: 1.
  - Worst case: `RANDOM_TRIES` + 256, after which FULL is reached.
- Eaten latency: `appleEaten` sampled at edge N clears the apple at edge N. The earliest new apple appears at edge N+1.
- All outputs are registered. `RedPixels` is never more than one-hot.

## Test plan
- Empty board, `enable`=1, release reset → at the 1st edge, apple at (0,1): `RedPixels[0][1]`=1, `appleValid`=1; all other bits 0.
- `snakePixels[0][1]`=1, rest empty, release reset → edge 1 rejects (0,1); edge 2 places the apple at (0,2).
- Board full except (9,9), release reset → the 16 random tries all miss (LFSR 01,02,04,…,25). Apple placed at (9,9) at exactly edge 170 (16 + 154).
- Board fully occupied → `boardFull`=1 at edge 272 with `RedPixels`=0. A later `appleEaten` pulse causes no change. Reset clears `boardFull`.
- Apple at (0,1) in PLACED:
  - Pulse `appleEaten` with `enable`=0 → no change.
  - Pulse with `enable`=1 → `RedPixels`=0 and `appleValid`=0 after that edge.
  - Next placement lands on a cell with `snakePixels`=0 and `RedPixels` is one-hot.
- Assert `reset` during SEARCH_SCAN → all outputs go to reset values immediately, before the next clk edge. After release, the search restarts at edge 1 with candidate (0,1).
